// File: rtl/sar_adc_ctrl_mc.sv
// SAR ADC sequencer: track/hold, binary-search DAC trials, multi-channel scan.
// Optional 4-pass oversampling per channel slot when SAR_OVS_EN is defined.
module sar_adc_ctrl_mc #(
   parameter  int RES        = 8,
   parameter  int NCH        = 4,
   parameter  int SAMPLE_CYC = 4,
   localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           cont,
   input  logic [CHW-1:0] ch_sel,
   input  logic           comp_in,
   output logic           sample,
   output logic           comp_clk,
   output logic [RES-1:0] dac_code,
   output logic [CHW-1:0] ch_out,
   output logic           busy,
   output logic [RES-1:0] data_out,
   output logic [CHW-1:0] data_ch,
   output logic           data_valid
);

   localparam int IW = (RES > 1) ? $clog2(RES) : 1;
   localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_STROBE,
      S_DECIDE,
      S_DONE
   } state_t;

   state_t         state_q, state_n;
   logic [SW-1:0]  cnt_q, cnt_n;
   logic [IW-1:0]  idx_q, idx_n;
   logic [RES-1:0] res_q, res_n;
   logic [CHW-1:0] ch_n, dch_n;
   logic [RES-1:0] dac_n, dout_n;
   logic           dv_n;
   logic           sel_ok;

`ifdef SAR_OVS_EN
   logic [RES+1:0] acc_q, acc_n;
   logic [1:0]     pass_q, pass_n;
`endif

   // Out-of-range channel requests fall back to channel 0.
   assign sel_ok = ({1'b0, ch_sel} < (CHW+1)'(NCH));

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      res_n   = res_q;
      ch_n    = ch_out;
      dac_n   = dac_code;
      dout_n  = data_out;
      dch_n   = data_ch;
      dv_n    = 1'b0;
`ifdef SAR_OVS_EN
      acc_n   = acc_q;
      pass_n  = pass_q;
`endif
      case (state_q)
         S_IDLE: begin
            dac_n = '0;
            if (start) begin
               state_n = S_SAMPLE;
               ch_n    = sel_ok ? ch_sel : '0;
               cnt_n   = '0;
               res_n   = '0;
`ifdef SAR_OVS_EN
               acc_n   = '0;
               pass_n  = '0;
`endif
            end
         end
         S_SAMPLE: begin
            dac_n = '0;
            if (cnt_q == SW'(SAMPLE_CYC - 1)) begin
               state_n = S_STROBE;
               idx_n   = IW'(RES - 1);
               dac_n   = res_q | (RES'(1) << idx_n);
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         S_STROBE: state_n = S_DECIDE;
         S_DECIDE: begin
            // Trial bit is kept only if the comparator saw Vin >= Vdac.
            res_n[idx_q] = comp_in;
            if (idx_q != '0) begin
               idx_n   = idx_q - 1'b1;
               state_n = S_STROBE;
               dac_n   = res_n | (RES'(1) << idx_n);
            end else begin
`ifdef SAR_OVS_EN
               acc_n = acc_q + {2'b00, res_n};
               if (pass_q != 2'd3) begin
                  pass_n  = pass_q + 2'd1;
                  state_n = S_SAMPLE;
                  cnt_n   = '0;
                  res_n   = '0;
                  dac_n   = '0;
               end else begin
                  state_n = S_DONE;
                  dout_n  = acc_n[RES+1:2];
                  dch_n   = ch_out;
                  dv_n    = 1'b1;
                  dac_n   = res_n;
               end
`else
               state_n = S_DONE;
               dout_n  = res_n;
               dch_n   = ch_out;
               dv_n    = 1'b1;
               dac_n   = res_n;
`endif
            end
         end
         S_DONE: begin
            dac_n = '0;
`ifdef SAR_OVS_EN
            acc_n  = '0;
            pass_n = '0;
`endif
            if (cont) begin
               state_n = S_SAMPLE;
               ch_n    = (ch_out == CHW'(NCH - 1)) ? '0 : ch_out + 1'b1;
               cnt_n   = '0;
               res_n   = '0;
            end else begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they align with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         res_q      <= '0;
         sample     <= 1'b0;
         comp_clk   <= 1'b0;
         dac_code   <= '0;
         ch_out     <= '0;
         busy       <= 1'b0;
         data_out   <= '0;
         data_ch    <= '0;
         data_valid <= 1'b0;
`ifdef SAR_OVS_EN
         acc_q      <= '0;
         pass_q     <= '0;
`endif
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         idx_q      <= idx_n;
         res_q      <= res_n;
         sample     <= (state_n == S_SAMPLE);
         comp_clk   <= (state_n == S_STROBE);
         dac_code   <= dac_n;
         ch_out     <= ch_n;
         busy       <= (state_n != S_IDLE);
         data_out   <= dout_n;
         data_ch    <= dch_n;
         data_valid <= dv_n;
`ifdef SAR_OVS_EN
         acc_q      <= acc_n;
         pass_q     <= pass_n;
`endif
      end
   end

endmodule

// File: doc/sar_adc_ctrl_mc.md
Name: sar_adc_ctrl_mc

Overview:
Parametrised successive-approximation controller for the analog SAR ADC macro. It sequences track/hold, drives the capacitive DAC code and comparator strobe, and resolves RES bits per conversion. It scans NCH analog mux channels, either single-shot or continuous round-robin. It sits between the TT digital I/O wrapper and the analog SAR core (DAC, comparator, input mux on ua[]).

Parameters:
RES, 8, conversion resolution in bits (2..12)
NCH, 4, number of analog input channels (1..8)
SAMPLE_CYC, 4, clock cycles the sample switch stays closed (>=1)
CHW, $clog2(NCH) (min 1), channel index width; derived, not overridden

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  request a conversion; accepted only in IDLE
cont  in  1  1 = continuous round-robin scan; sampled in DONE
ch_sel  in  CHW  first channel to convert; latched on accepted start
comp_in  in  1  comparator result; 1 = Vin >= Vdac
sample  out  1  sample switch closed (track) when 1
comp_clk  out  1  one-cycle comparator strobe
dac_code  out  RES  code driven to the capacitive DAC
ch_out  out  CHW  analog mux select
busy  out  1  high in every state except IDLE
data_out  out  RES  last conversion result; held until next DONE
data_ch  out  CHW  channel of data_out
data_valid  out  1  one-cycle pulse when data_out updates

Behaviour:
- Reset: state=IDLE; sample=0, comp_clk=0, dac_code=0, ch_out=0, busy=0, data_out=0, data_ch=0, data_valid=0. Reset in any state aborts the conversion immediately with no data_valid; it overrides start in the same cycle.
- All outputs are registered.
- States:
  - IDLE: dac_code=0. start=1 latches ch_sel into ch_out (ch_sel>=NCH maps to 0) and goes to SAMPLE.
  - SAMPLE: sample=1 for exactly SAMPLE_CYC cycles; dac_code=0; then goes to STROBE with bit index i=RES-1.
  - STROBE: dac_code = result | (1<<i); comp_clk=1 for this one cycle.
  - DECIDE: comp_in is sampled. If 1, bit i stays set; if 0, bit i clears. The same dac_code stays driven. If i>0, decrement i and go to STROBE; else go to DONE.
  - DONE: data_out=result, data_ch=ch_out, data_valid=1 for one cycle. If cont=1: ch_out=(ch_out+1) wrapping NCH-1 -> 0, then SAMPLE. Else IDLE.
- Latency: if start is accepted at edge k, data_valid is high during cycle k+SAMPLE_CYC+2*RES+1.
- start while busy is ignored, with no queuing. Holding start high in IDLE re-triggers on the cycle after returning to IDLE.
- Dropping cont mid-conversion takes effect only at DONE.
- Successive results: the result register clears to 0 on entry to SAMPLE. data_out is unaffected until DONE.
- NCH=1: ch_out is always 0; continuous mode reconverts channel 0.

Optional Feature:
SAR_OVS_EN
- Defined: each channel slot runs 4 back-to-back SAMPLE+SAR passes on the same channel, accumulated in a RES+2-bit register. At DONE, data_out = acc>>2 (truncated). data_valid pulses once per channel slot. Latency becomes 4*(SAMPLE_CYC+2*RES)+1. Reset clears the accumulator.
- Undefined: single pass per slot exactly as above; no accumulator logic is synthesised.

Test Plan:
1. Bench comparator model comp_in=(vin>=dac_code), RES=8, SAMPLE_CYC=4. vin=0xA5, start pulse, ch_sel=2 -> data_valid at cycle k+21, data_out=0xA5, data_ch=2. Trial dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
2. Boundaries: vin=0x00 -> data_out=0x00. vin=0xFF -> data_out=0xFF. comp_clk pulses exactly 8 times per conversion. sample is high exactly 4 cycles.
3. Continuous scan: cont=1, ch_sel=3, NCH=4, per-channel vin {0x10,0x20,0x30,0x40}. Results come out ch3=0x40, ch0=0x10, ch1=0x20, ch2=0x30, spaced 21 cycles. Drop cont -> IDLE after the current DONE.
4. start pulses during busy -> ignored: exactly one data_valid, busy never deasserts early.
5. rst asserted in cycle 10 of a conversion -> all outputs 0 next cycle, no data_valid, next start converts correctly.
6. With SAR_OVS_EN: vin alternating 0x40/0x43 per pass -> data_out=0x41 after 4*20+1=81 cycles, single data_valid.
